prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 12000000, meaning max idle clock cycles between bytes of a session before abort.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: rstn  in  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports: start  in  1  one-cycle request to begin a load session.
REQ-005 SHALL have ports: rx_data  in  8  byte from UART receiver.
REQ-006 SHALL have ports: rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have ports: mem_addr  out  9  word address to program memory.
REQ-008 SHALL have ports: mem_data  out  12  write data to program memory.
REQ-009 SHALL have ports: mem_wr  out  1  write enable to program memory, one cycle per word.
REQ-010 SHALL have ports: busy  out  1  session in progress; CPU held off while high.
REQ-011 SHALL have ports: done  out  1  last session completed successfully.
REQ-012 SHALL have ports: err  out  1  last session aborted.

Function
REQ-013 SHALL drive mem_addr, mem_data, mem_wr from registers/state only; no combinational path from inputs; memory samples them on the following falling edge.
REQ-014 SHALL implement states IDLE, CNT_LO, CNT_HI, DAT_LO, DAT_HI, WRITE; busy = (state != IDLE).
REQ-015 IDLE: start=1 -> CNT_LO; clear done, err, mem_addr=0, timer=0. start in any other state ignored.
REQ-016 CNT_LO: rx_valid -> count[7:0]=rx_data, -> CNT_HI.
REQ-017 CNT_HI: rx_valid -> count[9:8]=rx_data[1:0]; if rx_data[7:2]!=0, count==0 or count>512 -> err=1, IDLE; else -> DAT_LO.
REQ-018 DAT_LO: rx_valid -> latch low byte, -> DAT_HI.
REQ-019 DAT_HI: rx_valid -> if rx_data[7:4]!=0 -> err=1, IDLE, no write; else mem_data={rx_data[3:0], low byte}, -> WRITE.
REQ-020 WRITE: mem_wr=1 for exactly this one cycle at current mem_addr; on exit mem_addr+1, count-1; count reaching 0 -> done=1, IDLE; else -> DAT_LO.
REQ-021 rx_valid asserted while in WRITE -> byte lost: err=1, IDLE, this cycle's write still completes.
REQ-022 Timer: reset to 0 on entering CNT_LO and on every accepted byte; increments each cycle in CNT_LO/CNT_HI/DAT_LO/DAT_HI; reaching TIMEOUT without rx_valid -> err=1, IDLE.
REQ-023 Timer width SHALL hold TIMEOUT without overflow (>=24 bits at default).
REQ-024 mem_addr after 512th write increments to 0 (9-bit wrap); not used since session ends.
REQ-025 done and err mutually exclusive; both hold until next accepted start or reset.
REQ-026 rx_valid in IDLE ignored; words already written on abort are not rolled back.
REQ-027 mem_wr SHALL be 0 in every state except WRITE.

Reset
REQ-028 rstn=0 at a rising edge -> next cycle: state IDLE, mem_addr=0, mem_data=0, mem_wr=0, busy=0, done=0, err=0, count=0, timer=0; overrides start and rx_valid in same cycle.
REQ-029 Reset mid-session aborts without setting err; a later start begins again at address 0.

Verification
REQ-030 Normal load: start, bytes 03 00, 06 02, 40 00, 00 0E -> three single-cycle mem_wr: addr0=o1006, addr1=o0100, addr2=o7000; then done=1, busy=0, err=0.
REQ-031 Bad count: start, bytes 01 02 (513) -> err=1, busy=0, no mem_wr; same with 00 00 and 05 04.
REQ-032 Bad high byte: count 2, word 1 OK, word 2 bytes 12 1F -> one write at addr0 only, err=1, IDLE.
REQ-033 Timeout (TIMEOUT=16): start, byte 05 only, silence -> err=1 after exactly 16 idle cycles, no mem_wr; bytes arriving at 15-cycle gaps never time out.
REQ-034 Reset mid-load: after 2 of 4 words assert rstn=0 one cycle -> all outputs reset values; new start with count 1 writes addr0.
REQ-035 Full memory: count 512 (00 02), 512 words -> last write addr 511, mem_wr count exactly 512, done=1; start during session ignored.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a word count and 12-bit program words over a byte
// stream and writes them to program memory starting at address 0.
//
// Byte stream of one session:
//   count[7:0], {6'b0, count[9:8]}, then per word: data[7:0], {4'b0, data[11:8]}
//
// state  | meaning
// IDLE   | no session; waits for start, holds done/err of the last session
// CNT_LO | waiting for low byte of the word count
// CNT_HI | waiting for high byte of the word count, then range check
// DAT_LO | waiting for low byte of the next word
// DAT_HI | waiting for high byte of the next word
// WRITE  | one-cycle memory write of the assembled word
module prog_loader #(
  parameter int unsigned TIMEOUT = 12000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [8:0]  mem_addr,
  output logic [11:0] mem_data,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Timer must be able to hold TIMEOUT itself.
  localparam int unsigned TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort happens on the TIMEOUT-th consecutive cycle without a byte.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] CNT_HI = 3'd2;
  localparam logic [2:0] DAT_LO = 3'd3;
  localparam logic [2:0] DAT_HI = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;

  localparam logic [9:0] MAX_WORDS = 10'd512;

  logic [2:0]         state_q,    state_d;
  logic [9:0]         count_q,    count_d;
  logic [TIMER_W-1:0] timer_q,    timer_d;
  logic [7:0]         lo_q,       lo_d;
  logic [8:0]         mem_addr_q, mem_addr_d;
  logic [11:0]        mem_data_q, mem_data_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;

  logic [9:0]         cnt_new;
  logic               waiting;

  // Candidate word count formed from the stored low byte and the incoming high bits.
  always_comb begin
    cnt_new = {rx_data[1:0], count_q[7:0]};
  end

  // States in which the inter-byte timer runs and a byte may be accepted.
  always_comb begin
    waiting = (state_q == CNT_LO) || (state_q == CNT_HI) ||
              (state_q == DAT_LO) || (state_q == DAT_HI);
  end

  // Next-state and datapath logic for the whole session.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    lo_d       = lo_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = done_q;
    err_d      = err_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d    = CNT_LO;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_addr_d = 9'd0;
        timer_d    = '0;
      end
    end else if (waiting) begin
      if (rx_valid) begin
        // A byte arriving on the last allowed cycle still counts.
        timer_d = '0;
        case (state_q)
          CNT_LO: begin
            count_d = {count_q[9:8], rx_data};
            state_d = CNT_HI;
          end
          CNT_HI: begin
            count_d = cnt_new;
            if ((rx_data[7:2] != 6'd0) || (cnt_new == 10'd0) || (cnt_new > MAX_WORDS)) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DAT_LO;
            end
          end
          DAT_LO: begin
            lo_d    = rx_data;
            state_d = DAT_HI;
          end
          DAT_HI: begin
            if (rx_data[7:4] != 4'd0) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              mem_data_d = {rx_data[3:0], lo_q};
              state_d    = WRITE;
            end
          end
          default: state_d = IDLE;
        endcase
      end else if (timer_q == TIMER_LAST) begin
        err_d   = 1'b1;
        timer_d = '0;
        state_d = IDLE;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end else if (state_q == WRITE) begin
      // The write of this cycle always completes; a byte seen here has no
      // place to go and is reported as an abort rather than a success.
      mem_addr_d = mem_addr_q + 9'd1;
      count_d    = count_q - 10'd1;
      if (rx_valid) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (count_q == 10'd1) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = DAT_LO;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      count_q    <= 10'd0;
      timer_q    <= '0;
      lo_q       <= 8'd0;
      mem_addr_q <= 9'd0;
      mem_data_q <= 12'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      lo_q       <= lo_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Memory-side outputs come straight from registers or the state register.
  always_comb begin
    mem_addr = mem_addr_q;
    mem_data = mem_data_q;
    mem_wr   = (state_q == WRITE);
    busy     = (state_q != IDLE);
    done     = done_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a short timeout.
module tb_prog_loader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [8:0]  mem_addr;
  logic [11:0] mem_data;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  int          dbl    = 0;
  logic        wr_prev = 1'b0;
  logic [8:0]  log_addr [0:1023];
  logic [11:0] log_data [0:1023];
  int          base;

  prog_loader #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr   (mem_wr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write seen by the memory on the falling edge.
  always @(negedge clk) begin
    if (mem_wr) begin
      if (wr_cnt < 1024) begin
        log_addr[wr_cnt] = mem_addr;
        log_data[wr_cnt] = mem_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (mem_wr && wr_prev) dbl = dbl + 1;
    wr_prev = mem_wr;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap = 1);
    repeat (gap - 1) @(posedge clk);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] bc_lo [0:2];
  logic [7:0] bc_hi [0:2];

  initial begin
    bc_lo[0] = 8'h01; bc_hi[0] = 8'h02;
    bc_lo[1] = 8'h00; bc_hi[1] = 8'h00;
    bc_lo[2] = 8'h05; bc_hi[2] = 8'h04;

    // Reset overrides start and rx_valid
    rstn = 1'b0; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    settle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    start = 1'b0; rx_valid = 1'b0; rstn = 1'b1;
    settle(1);

    // Normal three-word load
    base = wr_cnt;
    do_start();
    chk("norm_busy_start", 32'(busy), 32'd1);
    send(8'h03); send(8'h00);
    send(8'h06); send(8'h02);
    send(8'h40); send(8'h00);
    send(8'h00); send(8'h0E);
    settle(2);
    chk("norm_nwr", 32'(wr_cnt - base), 32'd3);
    chk("norm_a0", 32'(log_addr[base]), 32'd0);
    chk("norm_d0", 32'(log_data[base]), 32'o1006);
    chk("norm_a1", 32'(log_addr[base+1]), 32'd1);
    chk("norm_d1", 32'(log_data[base+1]), 32'o0100);
    chk("norm_a2", 32'(log_addr[base+2]), 32'd2);
    chk("norm_d2", 32'(log_data[base+2]), 32'o7000);
    chk("norm_done", 32'(done), 32'd1);
    chk("norm_busy", 32'(busy), 32'd0);
    chk("norm_err", 32'(err), 32'd0);
    chk("norm_single", 32'(dbl), 32'd0);

    // Bytes in IDLE are ignored and done holds
    send(8'h55); send(8'hAA);
    settle(2);
    chk("idle_rx_done", 32'(done), 32'd1);
    chk("idle_rx_busy", 32'(busy), 32'd0);
    chk("idle_rx_nwr", 32'(wr_cnt - base), 32'd3);

    // Bad counts: 513, 0, 1029
    for (int i = 0; i < 3; i++) begin
      base = wr_cnt;
      do_start();
      chk("bc_done_clr", 32'(done), 32'd0);
      chk("bc_err_clr", 32'(err), 32'd0);
      send(bc_lo[i]); send(bc_hi[i]);
      settle(1);
      chk("bc_err", 32'(err), 32'd1);
      chk("bc_busy", 32'(busy), 32'd0);
      chk("bc_done", 32'(done), 32'd0);
      chk("bc_nwr", 32'(wr_cnt - base), 32'd0);
    end

    // Bad high data byte on second word
    base = wr_cnt;
    do_start();
    send(8'h02); send(8'h00);
    send(8'h34); send(8'h01);
    send(8'h12); send(8'h1F);
    settle(2);
    chk("bh_nwr", 32'(wr_cnt - base), 32'd1);
    chk("bh_a0", 32'(log_addr[base]), 32'd0);
    chk("bh_d0", 32'(log_data[base]), 32'h134);
    chk("bh_err", 32'(err), 32'd1);
    chk("bh_busy", 32'(busy), 32'd0);
    chk("bh_done", 32'(done), 32'd0);

    // Timeout after exactly 16 idle cycles
    base = wr_cnt;
    do_start();
    send(8'h05);
    settle(15);
    chk("to_busy_15", 32'(busy), 32'd1);
    chk("to_err_15", 32'(err), 32'd0);
    settle(1);
    chk("to_err_16", 32'(err), 32'd1);
    chk("to_busy_16", 32'(busy), 32'd0);
    chk("to_nwr", 32'(wr_cnt - base), 32'd0);

    // 15-cycle gaps never time out
    base = wr_cnt;
    do_start();
    send(8'h01, 15); send(8'h00, 15);
    send(8'hC3, 15); send(8'h0A, 15);
    settle(2);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_err", 32'(err), 32'd0);
    chk("gap_nwr", 32'(wr_cnt - base), 32'd1);
    chk("gap_d0", 32'(log_data[base]), 32'hAC3);

    // Reset mid-load after 2 of 4 words
    base = wr_cnt;
    do_start();
    send(8'h04); send(8'h00);
    send(8'h11); send(8'h00);
    send(8'h22); send(8'h00);
    settle(1);
    chk("mr_addr_pre", 32'(mem_addr), 32'd2);
    chk("mr_busy_pre", 32'(busy), 32'd1);
    chk("mr_nwr_pre", 32'(wr_cnt - base), 32'd2);
    rstn = 1'b0;
    settle(1);
    rstn = 1'b1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    chk("mr_data", 32'(mem_data), 32'd0);
    chk("mr_wr", 32'(mem_wr), 32'd0);
    base = wr_cnt;
    do_start();
    send(8'h01); send(8'h00);
    send(8'hAB); send(8'h05);
    settle(2);
    chk("mr2_nwr", 32'(wr_cnt - base), 32'd1);
    chk("mr2_a0", 32'(log_addr[base]), 32'd0);
    chk("mr2_d0", 32'(log_data[base]), 32'h5AB);
    chk("mr2_done", 32'(done), 32'd1);

    // Full memory: 512 words, start mid-session ignored
    base = wr_cnt;
    dbl  = 0;
    do_start();
    send(8'h00); send(8'h02);
    for (int i = 0; i < 512; i++) begin
      send(8'(i)); send(8'(i >> 8));
      if (i == 200) begin
        do_start();
        chk("full_start_busy", 32'(busy), 32'd1);
        chk("full_start_addr", 32'(mem_addr), 32'd201);
      end
    end
    settle(2);
    chk("full_nwr", 32'(wr_cnt - base), 32'd512);
    chk("full_a_first", 32'(log_addr[base]), 32'd0);
    chk("full_a_last", 32'(log_addr[base+511]), 32'd511);
    chk("full_d_last", 32'(log_data[base+511]), 32'd511);
    chk("full_d_mid", 32'(log_data[base+300]), 32'd300);
    chk("full_done", 32'(done), 32'd1);
    chk("full_err", 32'(err), 32'd0);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_wrap", 32'(mem_addr), 32'd0);
    chk("full_single", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
